// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
// Lets two requesters share one ALU_TOP. A round-robin arbiter picks one request,
// its operands/opcode are latched and driven to the ALU, the scheduler waits out
// the ALU's registered latency, selects the active unit's result by ALU_FUN[3:2]
// and returns it on a response channel. Only one op is ever in flight.
//
// Handshakes: on both channels a transfer happens at a rising CLK edge where
// valid && ready are both high. A producer holds valid and payload stable until
// that edge; ready may depend combinationally on valid (req_ready does), valid
// never depends on ready.
module alu_op_scheduler #(
    parameter int inWidth  = 8,
    parameter int outWidth = 16,
    parameter int ALU_LAT  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*inWidth-1:0] req_A,
    input  logic [2*inWidth-1:0] req_B,
    input  logic [7:0]           req_FUN,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [outWidth-1:0]  rsp_data,
    output logic                 rsp_carry,
    output logic                 busy,
    output logic [inWidth-1:0]   ALU_A,
    output logic [inWidth-1:0]   ALU_B,
    output logic [3:0]           ALU_FUN,
    input  logic [outWidth-1:0]  Arith_OUT,
    input  logic [outWidth-1:0]  Logic_OUT,
    input  logic [outWidth-1:0]  SHIFT_OUT,
    input  logic [3:0]           CMP_OUT,
    input  logic                 Carry_OUT,
    output logic [1:0]           o_dbg_state
);

    // Wait counter holds ALU_LAT-1, so it needs clog2(ALU_LAT) bits (at least 1).
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant;
    logic                w_accept;
    logic                r_last_grant;
    logic [inWidth-1:0]  r_a;
    logic [inWidth-1:0]  r_b;
    logic [3:0]          r_fun;
    logic                r_id;
    logic [CW-1:0]       r_cnt;
    logic [outWidth-1:0] w_result;
    logic                w_carry;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [outWidth-1:0] r_rsp_data;
    logic                r_rsp_carry;

    // The latched operands feed the ALU directly, so they change only on accept
    // and stay put through ISSUE/WAIT and while idle or responding.
    assign ALU_A       = r_a;
    assign ALU_B       = r_b;
    assign ALU_FUN     = r_fun;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_carry   = r_rsp_carry;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    // Next-state, round-robin grant and request accept.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        req_ready   = 2'b00;
        case (r_state)
            S_IDLE: begin
                // Tie goes to the requester that did not win last time.
                w_grant = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
                if (!RST && (req_valid != 2'b00)) begin
                    w_accept    = 1'b1;
                    req_ready   = w_grant ? 2'b10 : 2'b01;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result select by unit; only the arithmetic unit reports a carry.
    always_comb begin
        w_result = Arith_OUT;
        w_carry  = 1'b0;
        case (r_fun[3:2])
            2'b00: begin
                w_result = Arith_OUT;
                w_carry  = Carry_OUT;
            end
            2'b01:   w_result = Logic_OUT;
            2'b10:   w_result = {{(outWidth-4){1'b0}}, CMP_OUT};
            default: w_result = SHIFT_OUT;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, latency counter and response registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_fun        <= '0;
            r_id         <= 1'b0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_carry  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= w_grant ? req_A[2*inWidth-1:inWidth] : req_A[inWidth-1:0];
                r_b          <= w_grant ? req_B[2*inWidth-1:inWidth] : req_B[inWidth-1:0];
                r_fun        <= w_grant ? req_FUN[7:4] : req_FUN[3:0];
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= LAT_LOAD;
            end
            if (r_state == S_WAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_data  <= w_result;
                    r_rsp_carry <= w_carry;
                end
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
